hazard_scoreboard_unit: RTL

- Parametrised successor to the five-stage pipeline's hazard unit.
- Generates forwarding selects, load-use stalls and branch flushes for two register files: scalar (file 0) and vector (file 1).
- Adds a multi-cycle vector-op tracker: busy counter, per-register pending scoreboard, writeback strobe, and a saturating stall-cycle counter.
- Sits beside the Fetch/Decode/Execute/Memory/Writeback stages; all stage-register enables and flushes come from it.

---
 rtl/hazard_pkg.sv | 8 +
 rtl/hazard_scoreboard_unit_if.sv | 29 ++
 rtl/hazard_scoreboard_unit_mc_tracker.sv | 51 +++++
 rtl/hazard_scoreboard_unit.sv | 51 +++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared forwarding encodings and register-file identifiers
package hazard_pkg;
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W = 2'b01;
  localparam logic [1:0] FWD_M = 2'b10;
  localparam logic RF_SCALAR = 1'b0;
  localparam logic RF_VECTOR = 1'b1;
endpackage

// File: rtl/hazard_scoreboard_unit_if.sv
// hazard_scoreboard_unit_if: pipeline-stage register/control bundle seen by the hazard unit
interface hazard_scoreboard_unit_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W = 32
);
  logic [REG_AW-1:0] Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW;
  logic RfSelD, RegWriteD, McOpD;
  logic RfSelE, RegWriteE, ResultSrcE, McOpE;
  logic RfSelM, RegWriteM, RfSelW, RegWriteW, PCSrcE;
  logic [1:0] ForwardAE, ForwardBE;
  logic StallF, StallD, FlushD, FlushE;
  logic McBusy, McDone, McRf;
  logic [REG_AW-1:0] McRd;
  logic [CNT_W-1:0] StallCount;
  modport master (
    output Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW,
    output RfSelD, RegWriteD, McOpD, RfSelE, RegWriteE, ResultSrcE, McOpE,
    output RfSelM, RegWriteM, RfSelW, RegWriteW, PCSrcE,
    input ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
    input McBusy, McDone, McRf, McRd, StallCount
  );
  modport slave (
    input Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW,
    input RfSelD, RegWriteD, McOpD, RfSelE, RegWriteE, ResultSrcE, McOpE,
    input RfSelM, RegWriteM, RfSelW, RegWriteW, PCSrcE,
    output ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
    output McBusy, McDone, McRf, McRd, StallCount
  );
endinterface

// File: rtl/hazard_scoreboard_unit_mc_tracker.sv
// mc_tracker: latency counter, destination capture and pending scoreboard for the single in-flight multi-cycle op
module mc_tracker
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int MC_LAT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic issue,
  input  logic [REG_AW-1:0] rd,
  input  logic rf,
  output logic busy,
  output logic done,
  output logic [REG_AW-1:0] mc_rd,
  output logic mc_rf,
  output logic [1:0][2**REG_AW-1:0] pend
);
  logic [3:0] cnt_q, cnt_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic rf_q, rf_d;
  logic [1:0][2**REG_AW-1:0] pend_q, pend_d;
  assign busy = cnt_q != 4'd0;
  assign done = cnt_q == 4'd1;
  assign mc_rd = rd_q;
  assign mc_rf = rf_q;
  assign pend = pend_q;
  // count down the op latency; pending bit clears on the completion edge, scalar r0 is never tracked
  always_comb begin
    cnt_d = issue ? 4'(MC_LAT) : cnt_q - 4'(busy);
    rd_d = issue ? rd : rd_q;
    rf_d = issue ? rf : rf_q;
    pend_d = pend_q;
    if (done) pend_d[rf_q][rd_q] = 1'b0;
    if (issue && (rf == RF_VECTOR || rd != '0)) pend_d[rf][rd] = 1'b1;
  end
  // tracker state; reset aborts any op without a completion strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      rd_q <= '0;
      rf_q <= 1'b0;
      pend_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      rd_q <= rd_d;
      rf_q <= rf_d;
      pend_q <= pend_d;
    end
  end
endmodule

// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit: forwarding, stall/flush generation and multi-cycle op scoreboard for scalar and vector files
module hazard_scoreboard_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int MC_LAT = 4,
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic rst,
  hazard_scoreboard_unit_if.slave hz
);
  logic issue, lu, sb, isf, st, stall;
  logic [1:0][2**REG_AW-1:0] pend;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  function automatic logic rmatch(logic [REG_AW-1:0] a, logic fa, logic [REG_AW-1:0] b, logic fb);
    return a == b && fa == fb && !(fa == RF_SCALAR && a == '0);
  endfunction
  assign issue = hz.McOpE & hz.RegWriteE & ~hz.McBusy;
  mc_tracker #(.REG_AW(REG_AW), .MC_LAT(MC_LAT)) u_mc (
    .clk(clk), .rst(rst), .issue(issue), .rd(hz.RdE), .rf(hz.RfSelE),
    .busy(hz.McBusy), .done(hz.McDone), .mc_rd(hz.McRd), .mc_rf(hz.McRf), .pend(pend)
  );
  // forwarding selects and hazard detection; a taken branch overrides any stall
  always_comb begin
    hz.ForwardAE = !rst ? FWD_RF :
                   (hz.RegWriteM && rmatch(hz.Rs1E, hz.RfSelE, hz.RdM, hz.RfSelM)) ? FWD_M :
                   (hz.RegWriteW && rmatch(hz.Rs1E, hz.RfSelE, hz.RdW, hz.RfSelW)) ? FWD_W : FWD_RF;
    hz.ForwardBE = !rst ? FWD_RF :
                   (hz.RegWriteM && rmatch(hz.Rs2E, hz.RfSelE, hz.RdM, hz.RfSelM)) ? FWD_M :
                   (hz.RegWriteW && rmatch(hz.Rs2E, hz.RfSelE, hz.RdW, hz.RfSelW)) ? FWD_W : FWD_RF;
    lu = hz.ResultSrcE & hz.RegWriteE & (rmatch(hz.RdE, hz.RfSelE, hz.Rs1D, hz.RfSelD) |
         rmatch(hz.RdE, hz.RfSelE, hz.Rs2D, hz.RfSelD));
    sb = pend[hz.RfSelD][hz.Rs1D] | pend[hz.RfSelD][hz.Rs2D] | (hz.RegWriteD & pend[hz.RfSelD][hz.RdD]);
    isf = issue & (rmatch(hz.RdE, hz.RfSelE, hz.Rs1D, hz.RfSelD) | rmatch(hz.RdE, hz.RfSelE, hz.Rs2D, hz.RfSelD) |
          rmatch(hz.RdE, hz.RfSelE, hz.RdD, hz.RfSelD));
    st = hz.McOpD & (hz.McBusy | hz.McOpE);
    stall = rst & (lu | sb | isf | st);
    hz.StallF = stall & ~hz.PCSrcE;
    hz.StallD = stall & ~hz.PCSrcE;
    hz.FlushD = rst & hz.PCSrcE;
    hz.FlushE = stall | (rst & hz.PCSrcE);
    stall_count_d = (hz.StallF && stall_count_q != '1) ? stall_count_q + 1'b1 : stall_count_q;
  end
  assign hz.StallCount = stall_count_q;
  // saturating count of fetch-stall cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_count_q <= '0;
    else stall_count_q <= stall_count_d;
  end
endmodule
